// File: rtl/bus_arbiter_if.sv
// Bundle of all bus signals around bus_arbiter.
//   i_* : upstream side, one lane per initiator (initiator 0 in the LSBs)
//   o_* : downstream side towards the decoder/responder fabric
// Modports:
//   master : arbiter view. It drives i_ack/i_err/i_rdata upstream and
//            o_req/o_we/o_addr/o_wdata/o_be downstream.
//   slave  : environment view. Initiators and the responder use it, so
//            every direction is the opposite of master.
interface bus_arbiter_if #(
  parameter int unsigned NumInitiators = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32
);
  logic [NumInitiators-1:0]             i_req;
  logic [NumInitiators-1:0]             i_we;
  logic [NumInitiators*AddrWidth-1:0]   i_addr;
  logic [NumInitiators*DataWidth-1:0]   i_wdata;
  logic [NumInitiators*DataWidth/8-1:0] i_be;
  logic [NumInitiators-1:0]             i_ack;
  logic [NumInitiators-1:0]             i_err;
  logic [DataWidth-1:0]                 i_rdata;

  logic                                 o_req;
  logic                                 o_we;
  logic [AddrWidth-1:0]                 o_addr;
  logic [DataWidth-1:0]                 o_wdata;
  logic [DataWidth/8-1:0]               o_be;
  logic                                 o_ack;
  logic [DataWidth-1:0]                 o_rdata;

  modport master (
    input  i_req, i_we, i_addr, i_wdata, i_be, o_ack, o_rdata,
    output i_ack, i_err, i_rdata, o_req, o_we, o_addr, o_wdata, o_be
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata, i_be, o_ack, o_rdata,
    input  i_ack, i_err, i_rdata, o_req, o_we, o_addr, o_wdata, o_be
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter merging NumInitiators request/acknowledge ports onto
// one downstream bus. One grant is held per transaction; the granted
// initiator's request is forwarded unchanged and the single ack/read data
// are routed back to that initiator only. After each completed transaction
// the arbiter spends one IDLE cycle before granting again.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-high reset
//   bus   : bus_arbiter_if.master (upstream i_* lanes, downstream o_*)
//   grant : index of the current owner, for debug/trace
//
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to enable a watchdog that
// completes a transaction with i_err after TimeoutCycles BUSY cycles
// without o_ack. Without the macro BUSY waits for o_ack indefinitely.
module bus_arbiter #(
  parameter int unsigned NumInitiators = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255,
  localparam int unsigned GrantWidth   = $clog2(NumInitiators)
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_arbiter_if.master         bus,
  output logic [GrantWidth-1:0] grant
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [GrantWidth-1:0] grant_q, grant_d;
  logic [GrantWidth-1:0] rr_q, rr_d;

  logic                  busy;
  logic                  timeout;
  logic                  done;
  logic                  found;
  logic [GrantWidth-1:0] pick;
  logic [GrantWidth:0]   cand;
  logic [NumInitiators-1:0] grant_oh;

  assign busy     = (state_q == BUSY);
  assign grant_oh = NumInitiators'(1) << grant_q;
  assign done     = busy && (bus.o_ack || timeout);
  assign grant    = grant_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // o_ack in the timeout cycle takes priority and completes normally.
  assign timeout = busy && !bus.o_ack && (cnt_q == CntWidth'(TimeoutCycles));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (found) cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Search upward from rr, wrapping at NumInitiators-1. cand carries one
  // extra bit so rr + i cannot overflow before the wrap subtraction.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NumInitiators; i++) begin
      cand = {1'b0, rr_q} + (GrantWidth+1)'(i);
      if (cand >= (GrantWidth+1)'(NumInitiators)) begin
        cand = cand - (GrantWidth+1)'(NumInitiators);
      end
      if (!found && bus.i_req[cand[GrantWidth-1:0]]) begin
        found = 1'b1;
        pick  = cand[GrantWidth-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          rr_d    = (grant_q == GrantWidth'(NumInitiators - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Downstream request: forwarded from the owner while BUSY, zero otherwise.
  always_comb begin
    bus.o_req   = busy;
    bus.o_we    = 1'b0;
    bus.o_addr  = '0;
    bus.o_wdata = '0;
    bus.o_be    = '0;
    if (busy) begin
      bus.o_we    = bus.i_we[grant_q];
      bus.o_addr  = bus.i_addr[grant_q*AddrWidth +: AddrWidth];
      bus.o_wdata = bus.i_wdata[grant_q*DataWidth +: DataWidth];
      bus.o_be    = bus.i_be[grant_q*(DataWidth/8) +: DataWidth/8];
    end
  end

  // Upstream response: combinational from o_ack, only to the owner.
  always_comb begin
    bus.i_ack   = done ? grant_oh : '0;
    bus.i_err   = timeout ? grant_oh : '0;
    bus.i_rdata = (busy && bus.o_ack) ? bus.o_rdata : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned T  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NumInitiators(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  bus_arbiter #(
    .NumInitiators(N),
    .AddrWidth(AW),
    .DataWidth(DW),
    .TimeoutCycles(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant(grant)
  );

  typedef struct {
    int unsigned    who;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BW-1:0]  be;
  } req_t;

  typedef struct {
    int unsigned    who;
    logic [DW-1:0]  rdata;
    logic           err;
  } rsp_t;

  req_t exp_grant_q[$];
  rsp_t exp_ack_q[$];
  int unsigned grant_log[$];

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // Reference model: transaction-level view of the arbiter.
  bit          pend[N];
  req_t        fld[N];
  int unsigned m_rr;
  bit          m_free;
  int unsigned m_owner;
  int          m_wait;
  int unsigned m_bc;
  bit          m_done_now;
  bit          exp_oreq;

  int          forced_wait = -1;
  int unsigned gen_pct     = 0;
  bit          use_rd_fixed = 1'b0;
  logic [DW-1:0] rd_fixed;
  bit          mon_on = 1'b0;
  bit          prev_oreq = 1'b0;
  req_t        cur;
  int unsigned err_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int unsigned w);
    logic [N-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.i_req[i]            = pend[i];
      bus.i_we[i]             = fld[i].we;
      bus.i_addr[i*AW +: AW]  = fld[i].addr;
      bus.i_wdata[i*DW +: DW] = fld[i].wdata;
      bus.i_be[i*BW +: BW]    = fld[i].be;
    end
  endtask

  task automatic randomize_fields(input int i);
    fld[i].who   = i;
    fld[i].we    = 1'($urandom);
    fld[i].addr  = $urandom;
    fld[i].wdata = $urandom;
    fld[i].be    = BW'($urandom);
  endtask

  // One clock cycle of stimulus; model updated for the edge just passed.
  task automatic step();
    bit got;
    @(posedge clk);
    #1;
    if (!m_free && m_done_now) begin
      pend[m_owner] = 1'b0;
      m_rr          = (m_owner + 1) % N;
      m_free        = 1'b1;
      m_done_now    = 1'b0;
    end else if (m_free) begin
      got = 1'b0;
      for (int k = 0; k < N; k++) begin
        int unsigned c;
        c = (m_rr + k) % N;
        if (!got && pend[c]) begin
          got     = 1'b1;
          m_owner = c;
        end
      end
      if (got) begin
        m_free = 1'b0;
        m_bc   = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        m_wait = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 7));
`else
        m_wait = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
`endif
        exp_grant_q.push_back(fld[m_owner]);
      end
    end
    exp_oreq = !m_free;

    bus.o_ack   = 1'b0;
    bus.o_rdata = $urandom;
    if (!m_free) begin
      m_bc++;
      if (m_wait == 0) begin
        rsp_t r;
        if (use_rd_fixed) bus.o_rdata = rd_fixed;
        bus.o_ack = 1'b1;
        r.who = m_owner; r.rdata = bus.o_rdata; r.err = 1'b0;
        exp_ack_q.push_back(r);
        m_done_now = 1'b1;
      end else begin
        m_wait--;
`ifdef BUS_ARBITER_TIMEOUT_EN
        if (m_bc == T + 1) begin
          rsp_t r;
          r.who = m_owner; r.rdata = '0; r.err = 1'b1;
          exp_ack_q.push_back(r);
          m_done_now = 1'b1;
        end
`endif
      end
    end else begin
      bus.o_ack = ($urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        randomize_fields(i);
        if ($urandom_range(0, 99) < gen_pct) pend[i] = 1'b1;
      end
    end
    drive_inputs();
  endtask

  task automatic drain();
    bit drained;
    gen_pct     = 0;
    forced_wait = 0;
    drained     = 1'b0;
    for (int k = 0; k < 50 && !drained; k++) begin
      step();
      drained = m_free && !m_done_now && !pend[0] && !pend[1] && !pend[2];
    end
    check("drain", {127'b0, drained}, 128'd1);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("o_req", {127'b0, bus.o_req}, {127'b0, exp_oreq});
      if (bus.o_req && !prev_oreq) begin
        if (exp_grant_q.size() == 0) begin
          check("grant_unexpected", {127'b0, bus.o_req}, 128'd0);
        end else begin
          cur = exp_grant_q.pop_front();
          grant_log.push_back(cur.who);
          check("grant", {126'b0, grant}, 128'(cur.who));
        end
      end
      if (bus.o_req) begin
        check("o_fields", {bus.o_we, bus.o_addr, bus.o_wdata, bus.o_be},
              {cur.we, cur.addr, cur.wdata, cur.be});
      end else begin
        check("o_idle_zero", {bus.o_we, bus.o_addr, bus.o_wdata, bus.o_be}, 128'd0);
      end
      if (bus.i_ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          check("stray_ack", {125'b0, bus.i_ack}, 128'd0);
        end else begin
          rsp_t r;
          r = exp_ack_q.pop_front();
          if (bus.i_err != '0) err_seen++;
          check("ack", {bus.i_ack, bus.i_err, bus.i_rdata},
                {oh(r.who), (r.err ? oh(r.who) : N'(0)), r.rdata});
        end
      end else begin
        check("no_ack_zero", {bus.i_err, bus.i_rdata}, 128'd0);
      end
      prev_oreq = bus.o_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst         = 1'b1;
    bus.o_ack   = 1'b0;
    bus.o_rdata = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      randomize_fields(i);
    end
    drive_inputs();
    m_rr = 0; m_free = 1'b1; m_done_now = 1'b0; exp_oreq = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_req", {127'b0, bus.o_req}, 128'd0);
    check("rst_i_ack", {122'b0, bus.i_ack, bus.i_err}, 128'd0);
    check("rst_grant", {126'b0, grant}, 128'd0);
    @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Single read from initiator 1, responder acks after 3 wait cycles.
    pend[1]       = 1'b1;
    fld[1].we     = 1'b0;
    fld[1].addr   = 32'h0000_1000;
    fld[1].be     = 4'hF;
    drive_inputs();
    gen_pct      = 0;
    forced_wait  = 3;
    use_rd_fixed = 1'b1;
    rd_fixed     = 32'hDEAD_BEEF;
    grant_log.delete();
    repeat (8) step();
    use_rd_fixed = 1'b0;
    check("single_grant_cnt", 128'(grant_log.size()), 128'd1);
    check("single_ack_done", 128'(exp_ack_q.size()), 128'd0);

    // rr now points at 2; requests on 0 and 1 must wrap to 0 first.
    drain();
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    drive_inputs();
    grant_log.delete();
    repeat (8) step();
    check("wrap_cnt", 128'(grant_log.size()), 128'd2);
    if (grant_log.size() >= 2) begin
      check("wrap_first", 128'(grant_log[0]), 128'd0);
      check("wrap_second", 128'(grant_log[1]), 128'd1);
    end

    // Continuous requests from all, zero-wait responder: 2,0,1,2,0,1.
    drain();
    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    drive_inputs();
    gen_pct     = 100;
    forced_wait = 0;
    grant_log.delete();
    repeat (12) step();
    check("rr_cnt", 128'(grant_log.size()), 128'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      check("rr_seq", 128'(grant_log[k]), 128'((2 + k) % 3));
    end

    // Randomized traffic.
    drain();
    gen_pct     = 30;
    forced_wait = -1;
    repeat (400) step();

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Responder never acks, then acks exactly in the timeout cycle.
    drain();
    err_seen    = 0;
    pend[1]     = 1'b1;
    drive_inputs();
    forced_wait = 100;
    repeat (8) step();
    check("timeout_err", 128'(err_seen), 128'd1);
    drain();
    pend[2]     = 1'b1;
    drive_inputs();
    forced_wait = T;
    repeat (8) step();
    check("timeout_coincide", 128'(err_seen), 128'd1);
`endif

    // Reset in the middle of a BUSY transaction.
    drain();
    pend[0]     = 1'b1;
    drive_inputs();
    forced_wait = 10;
    repeat (2) step();
    mon_on    = 1'b0;
    rst       = 1'b1;
    bus.o_ack = 1'b1;
    @(negedge clk);
    check("midrst_o_req", {127'b0, bus.o_req}, 128'd0);
    check("midrst_i_ack", {125'b0, bus.i_ack}, 128'd0);
    check("midrst_grant", {126'b0, grant}, 128'd0);
    exp_grant_q.delete();
    exp_ack_q.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_inputs();
    m_rr = 0; m_free = 1'b1; m_done_now = 1'b0; exp_oreq = 1'b0;
    rst       = 1'b0;
    prev_oreq = 1'b0;
    mon_on    = 1'b1;
    gen_pct   = 0;
    repeat (5) step();

    // Pointer restarts at 0 after reset: requests on 0 and 2 -> 0 then 2.
    pend[0] = 1'b1;
    pend[2] = 1'b1;
    drive_inputs();
    forced_wait = 1;
    grant_log.delete();
    repeat (10) step();
    check("postrst_cnt", 128'(grant_log.size()), 128'd2);
    if (grant_log.size() >= 2) begin
      check("postrst_first", 128'(grant_log[0]), 128'd0);
      check("postrst_second", 128'(grant_log[1]), 128'd2);
    end

    drain();
    check("grant_q_empty", 128'(exp_grant_q.size()), 128'd0);
    check("ack_q_empty", 128'(exp_ack_q.size()), 128'd0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
